key_matrix_scan: RTL

//  Input-direction counterpart of the LED dot-matrix row scanner.
//  - Drives a 4x4 push-button matrix: one active-low row at a time.
//  - Reads the four active-low column lines, debounces whole scans and

---
 rtl/key_pkg.sv | 38 +++
 rtl/key_scan_timer.sv | 56 +++++
 rtl/key_matrix_scan.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// ============================================================================
// Module      : key_pkg
// Description : Shared types and constants for the 4x4 key matrix scanner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package key_pkg;

  localparam int KEY_ROWS = 4;
  localparam int KEY_COLS = 4;

  // All rows released (active-low drive, nothing selected)
  localparam logic [3:0] ROW_IDLE = 4'b1111;

  // {row[1:0], col[1:0]}
  typedef logic [3:0] key_code_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DEB_P   = 2'd1,
    PRESSED = 2'd2,
    DEB_R   = 2'd3
  } key_state_e;

  // Number of pressed positions seen in one full scan
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_scan_timer.sv
// ============================================================================
// Module      : key_scan_timer
// Description : Row-rate divider and active-low one-hot row driver. Strobes
//               o_sample on the last (settled) divider count of every row and
//               o_scan_done on the row-3 sample.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_scan_timer #(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [1:0] o_row_idx,
  output logic [3:0] o_row_out,
  output logic       o_sample,
  output logic       o_scan_done
);
  import key_pkg::*;

  localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_row_idx;
  logic [3:0]       r_row_out;
  logic             w_sample;

  // Sample strobes derived from the current divider/row position
  always_comb begin
    w_sample    = (r_div == DIV_LAST);
    o_sample    = w_sample;
    o_scan_done = w_sample && (r_row_idx == 2'd3);
    o_row_idx   = r_row_idx;
    o_row_out   = r_row_out;
  end

  // Divider and row rotation; the row moves on right after its sample
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div     <= '0;
      r_row_idx <= 2'd0;
      r_row_out <= ROW_IDLE & ~4'b0001;
    end else if (w_sample) begin
      r_div     <= '0;
      r_row_idx <= r_row_idx + 2'd1;
      r_row_out <= {r_row_out[2:0], r_row_out[3]};
    end else begin
      r_div     <= r_div + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/key_matrix_scan.sv
// ============================================================================
// Module      : key_matrix_scan
// Description : 4x4 push-button matrix scanner with whole-scan debounce.
//               Reports one key code per press; a scan with zero or several
//               pressed positions counts as "no key".
//               Optional macro KEY_REPEAT_EN adds auto-repeat of key_valid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_matrix_scan #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEB_SCANS    = 4,
  parameter int REPEAT_DELAY = 100,
  parameter int REPEAT_RATE  = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  import key_pkg::*;

  localparam int              CNT_W   = (DEB_SCANS > 1) ? $clog2(DEB_SCANS + 1) : 1;
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]                   w_row_idx;
  logic                         w_sample;
  logic                         w_scan_done;
  logic [KEY_ROWS*KEY_COLS-1:0] r_acc;
  logic [KEY_ROWS*KEY_COLS-1:0] w_scan;
  logic                         w_hit;
  logic                         w_match;
  key_code_t                    w_code;

  key_state_e  r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  key_code_t   r_cand, w_cand_nxt;
  key_code_t   r_key_code;
  logic        r_valid;
  logic        w_accept;
  logic        w_rep_clr;
  logic        w_stay;
  logic        w_rep_fire;

  key_scan_timer #(
    .SCAN_DIV (SCAN_DIV)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .o_row_idx   (w_row_idx),
    .o_row_out   (row_out),
    .o_sample    (w_sample),
    .o_scan_done (w_scan_done)
  );

  // Merge the current row sample into the scan image and decode it
  always_comb begin
    w_scan = r_acc;
    w_scan[w_row_idx*KEY_COLS +: KEY_COLS] = ~col_in;
    w_code = '0;
    for (int k = 0; k < KEY_ROWS*KEY_COLS; k++) begin
      if (w_scan[k]) w_code = 4'(k);
    end
    w_hit   = (popcount16(w_scan) == 5'd1);
    w_match = w_hit && (w_code == r_cand);
  end

  // Scan accumulator: one pressed-high nibble per row
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (w_sample) begin
      r_acc <= w_scan;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state and debounce bookkeeping, only moves on scan_done
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    w_accept    = 1'b0;
    w_rep_clr   = 1'b0;
    w_stay      = 1'b0;
    w_cnt_inc   = (r_cnt == DEB_MAX) ? r_cnt : r_cnt + 1'b1;
    if (w_scan_done) begin
      case (r_state)
        IDLE: begin
          if (w_hit) begin
            w_cand_nxt = w_code;
            w_cnt_nxt  = CNT_ONE;
            if (CNT_ONE == DEB_MAX) begin
              w_state_nxt = PRESSED;
              w_accept    = 1'b1;
            end else begin
              w_state_nxt = DEB_P;
            end
          end
        end
        DEB_P: begin
          if (w_match) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == DEB_MAX) begin
              w_state_nxt = PRESSED;
              w_accept    = 1'b1;
            end
          end else begin
            // Any disagreement restarts from scratch, even another single key
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end
        end
        PRESSED: begin
          if (w_match) begin
            w_stay = 1'b1;
          end else if (CNT_ONE == DEB_MAX) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = DEB_R;
            w_cnt_nxt   = CNT_ONE;
          end
        end
        DEB_R: begin
          if (w_match) begin
            w_state_nxt = PRESSED;
            w_rep_clr   = 1'b1;
          end else begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == DEB_MAX) begin
              w_state_nxt = IDLE;
              w_cnt_nxt   = '0;
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Debounce counter, candidate code, accepted code and valid pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_cand     <= '0;
      r_key_code <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_cand  <= w_cand_nxt;
      r_valid <= w_accept || w_rep_fire;
      if (w_accept) r_key_code <= w_cand_nxt;
    end
  end

  // FSM outputs: the key stays held through release debounce
  always_comb begin
    key_held  = (r_state == PRESSED) || (r_state == DEB_R);
    key_valid = r_valid;
    key_code  = r_key_code;
  end

`ifdef KEY_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DLY = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] REP_RT  = REP_W'(REPEAT_RATE);

  logic [REP_W-1:0] r_rep_cnt;
  logic [REP_W-1:0] w_rep_inc;
  logic             r_rep_phase;

  // First repeat waits REPEAT_DELAY scans, later ones REPEAT_RATE scans
  always_comb begin
    w_rep_inc  = r_rep_cnt + 1'b1;
    w_rep_fire = w_stay && (w_rep_inc == (r_rep_phase ? REP_RT : REP_DLY));
  end

  // Repeat scan counter, restarted whenever PRESSED is (re)entered
  always_ff @(posedge clk) begin
    if (rst || w_accept || w_rep_clr) begin
      r_rep_cnt   <= '0;
      r_rep_phase <= 1'b0;
    end else if (w_stay) begin
      if (w_rep_fire) begin
        r_rep_cnt   <= '0;
        r_rep_phase <= 1'b1;
      end else begin
        r_rep_cnt   <= w_rep_inc;
      end
    end
  end
`else
  logic w_unused_rep;
  assign w_rep_fire   = 1'b0;
  assign w_unused_rep = ^{w_stay, w_rep_clr, REPEAT_DELAY, REPEAT_RATE};
`endif

endmodule

`default_nettype wire
